// File: rtl/cpu4_mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, funct codes,
// ALU control codes, FSM states and the packed control word.
package cpu4_mc_ctrl_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // pcen has three sources: FETCH (qualified by mem_ready), BRANCH (by zero), JUMP.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite_en;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       pcen_mr;
        logic       pcen_zero;
        logic       pcen_one;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        mem_req:    1'b1,
        iord:       1'b0,
        irwrite_en: 1'b1,
        memwrite:   1'b0,
        regdst:     1'b0,
        memtoreg:   1'b0,
        regwrite:   1'b0,
        alusrca:    1'b0,
        alusrcb:    2'b01,
        pcsrc:      2'b00,
        alucontrol: ALU_ADD,
        pcen_mr:    1'b1,
        pcen_zero:  1'b0,
        pcen_one:   1'b0
    };

    function automatic logic op_supported(input logic [5:0] op_v);
        logic ok_v;
        case (op_v)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok_v = 1'b1;
            default:                                       ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

endpackage

// File: rtl/cpu4_mc_ctrl_aludec.sv
// Combinational R-type funct to ALU control decoder with a validity flag.
module cpu4_aludec
    import cpu4_mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       valid
);

    // funct lookup; unsupported codes report invalid and select AND (all zeros).
    always_comb begin
        alucontrol = ALU_AND;
        valid      = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: begin
                alucontrol = ALU_AND;
                valid      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu4_mc_ctrl_flopr.sv
// Reset flop primitive: asynchronous active-low reset to a fixed value.
module cpu4_flopr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu4_mc_ctrl.sv
// Multicycle CPU control FSM. The control word is registered from the next
// state so each output is a glitch-free Moore decode of the current state.
module cpu4_mc_ctrl
    import cpu4_mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       illegal_op
);

    logic [3:0] state_q_r;
    state_t     state_r;
    state_t     state_nxt_s;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_nxt_s;
    logic [2:0] funct_alu_s;
    logic       funct_ok_s;
    logic       illegal_s;

    cpu4_aludec u_aludec (
        .funct      (funct),
        .alucontrol (funct_alu_s),
        .valid      (funct_ok_s)
    );

    cpu4_flopr #(
        .WIDTH     (4),
        .RESET_VAL (S_FETCH)
    ) u_state_reg (
        .clk   (clk),
        .rst_n (reset),
        .d     (state_nxt_s),
        .q     (state_q_r)
    );

    assign state_r = state_t'(state_q_r);

    // Next-state selection.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) state_nxt_s = S_DECODE;
                else           state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_EXECUTE;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_ADDI:      state_nxt_s = S_ADDIEXEC;
                    OP_J:         state_nxt_s = S_JUMP;
                    default:      state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) state_nxt_s = S_MEMWR;
                else             state_nxt_s = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_nxt_s = S_MEMWB;
                else           state_nxt_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) state_nxt_s = S_FETCH;
                else           state_nxt_s = S_MEMWR;
            end
            S_EXECUTE: begin
                if (funct_ok_s) state_nxt_s = S_ALUWB;
                else            state_nxt_s = S_FETCH;
            end
            S_ADDIEXEC: state_nxt_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nxt_s = S_FETCH;
            default:    state_nxt_s = S_FETCH;
        endcase
    end

    // Control word for the state being entered; funct is already valid in DECODE.
    always_comb begin
        ctrl_nxt_s = '0;
        case (state_nxt_s)
            S_FETCH: ctrl_nxt_s = CTRL_FETCH;
            S_DECODE: begin
                ctrl_nxt_s.alusrcb    = 2'b11;
                ctrl_nxt_s.alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl_nxt_s.alusrca    = 1'b1;
                ctrl_nxt_s.alusrcb    = 2'b10;
                ctrl_nxt_s.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_nxt_s.mem_req = 1'b1;
                ctrl_nxt_s.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_nxt_s.memtoreg = 1'b1;
                ctrl_nxt_s.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_nxt_s.mem_req  = 1'b1;
                ctrl_nxt_s.iord     = 1'b1;
                ctrl_nxt_s.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_nxt_s.alusrca    = 1'b1;
                ctrl_nxt_s.alucontrol = funct_alu_s;
            end
            S_ALUWB: begin
                ctrl_nxt_s.regdst   = 1'b1;
                ctrl_nxt_s.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_nxt_s.alusrca    = 1'b1;
                ctrl_nxt_s.alucontrol = ALU_SUB;
                ctrl_nxt_s.pcsrc      = 2'b01;
                ctrl_nxt_s.pcen_zero  = 1'b1;
            end
            S_ADDIWB: ctrl_nxt_s.regwrite = 1'b1;
            S_JUMP: begin
                ctrl_nxt_s.pcsrc    = 2'b10;
                ctrl_nxt_s.pcen_one = 1'b1;
            end
            default: ctrl_nxt_s = CTRL_FETCH;
        endcase
    end

    cpu4_flopr #(
        .WIDTH     ($bits(ctrl_t)),
        .RESET_VAL (CTRL_FETCH)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (reset),
        .d     (ctrl_nxt_s),
        .q     (ctrl_r)
    );

    // op/funct only become valid once the instruction register is loaded, so this cannot be registered ahead.
    always_comb begin
        if (state_r == S_DECODE) begin
            illegal_s = !op_supported(op);
        end else if (state_r == S_EXECUTE) begin
            illegal_s = !funct_ok_s;
        end else begin
            illegal_s = 1'b0;
        end
    end

    assign mem_req    = ctrl_r.mem_req;
    assign iord       = ctrl_r.iord;
    assign memwrite   = ctrl_r.memwrite;
    assign regdst     = ctrl_r.regdst;
    assign memtoreg   = ctrl_r.memtoreg;
    assign regwrite   = ctrl_r.regwrite;
    assign alusrca    = ctrl_r.alusrca;
    assign alusrcb    = ctrl_r.alusrcb;
    assign pcsrc      = ctrl_r.pcsrc;
    assign alucontrol = ctrl_r.alucontrol;
    assign illegal_op = illegal_s;
    // The gated strobes are masked by reset so nothing commits while it is held.
    assign irwrite    = ctrl_r.irwrite_en & mem_ready & reset;
    assign pcen       = reset & ((ctrl_r.pcen_mr & mem_ready) |
                                 (ctrl_r.pcen_zero & zero) |
                                 ctrl_r.pcen_one);

endmodule

// File: tb/tb_cpu4_mc_ctrl.sv
// Directed bench for cpu4_mc_ctrl with a per-cycle behavioural reference.
module tb_cpu4_mc_ctrl;

    localparam int M_FETCH = 0, M_DECODE = 1, M_MEMADR = 2, M_MEMRD = 3,
                   M_MEMWB = 4, M_MEMWR = 5, M_EXEC = 6, M_ALUWB = 7,
                   M_BRANCH = 8, M_ADDIEX = 9, M_ADDIWB = 10, M_JUMP = 11;
    localparam logic [16:0] RST_VEC = 17'b1_0_0_0_0_0_0_0_01_00_010_0_0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [16:0] got;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int ph = M_FETCH;

    always #5 clk = ~clk;

    cpu4_mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .irwrite(irwrite),
        .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .pcen(pcen), .illegal_op(illegal_op)
    );

    assign got = {mem_req, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal_op};

    function automatic int alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic bit op_ok(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    function automatic int mnext(input int p, input logic [5:0] o, input logic [5:0] f, input logic mr);
        case (p)
            M_FETCH:  return mr ? M_DECODE : M_FETCH;
            M_DECODE: begin
                if (o == 6'b100011 || o == 6'b101011) return M_MEMADR;
                if (o == 6'b000000) return M_EXEC;
                if (o == 6'b000100) return M_BRANCH;
                if (o == 6'b001000) return M_ADDIEX;
                if (o == 6'b000010) return M_JUMP;
                return M_FETCH;
            end
            M_MEMADR: return (o == 6'b101011) ? M_MEMWR : M_MEMRD;
            M_MEMRD:  return mr ? M_MEMWB : M_MEMRD;
            M_MEMWR:  return mr ? M_FETCH : M_MEMWR;
            M_EXEC:   return (alu_of(f) >= 0) ? M_ALUWB : M_FETCH;
            M_ADDIEX: return M_ADDIWB;
            default:  return M_FETCH;
        endcase
    endfunction

    function automatic logic [16:0] mexp(input int p, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic mr, input logic rn);
        logic mq, io, irw, mw, rd, m2r, rw, asa, pce, ill;
        logic [1:0] asb, ps;
        logic [2:0] ac;
        int a;
        {mq, io, irw, mw, rd, m2r, rw, asa, pce, ill} = 10'd0;
        asb = 2'b00; ps = 2'b00; ac = 3'b000;
        if (!rn) p = M_FETCH;
        case (p)
            M_FETCH:  begin mq = 1'b1; asb = 2'b01; ac = 3'b010; irw = mr & rn; pce = mr & rn; end
            M_DECODE: begin asb = 2'b11; ac = 3'b010; ill = !op_ok(o); end
            M_MEMADR, M_ADDIEX: begin asa = 1'b1; asb = 2'b10; ac = 3'b010; end
            M_MEMRD:  begin mq = 1'b1; io = 1'b1; end
            M_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
            M_MEMWR:  begin mq = 1'b1; io = 1'b1; mw = 1'b1; end
            M_EXEC:   begin
                asa = 1'b1; a = alu_of(f);
                if (a >= 0) ac = a[2:0]; else ill = 1'b1;
            end
            M_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
            M_BRANCH: begin asa = 1'b1; ac = 3'b110; ps = 2'b01; pce = z; end
            M_ADDIWB: rw = 1'b1;
            M_JUMP:   begin ps = 2'b10; pce = 1'b1; end
            default:  ;
        endcase
        return {mq, io, irw, mw, rd, m2r, rw, asa, asb, ps, ac, pce, ill};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) ph <= M_FETCH;
        else        ph <= mnext(ph, op, funct, mem_ready);
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (chk_en) begin
            e = mexp(ph, op, funct, zero, mem_ready, reset);
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t phase=%0d got=%b required=%b", $time, ph, got, e);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Runs one instruction from FETCH to the next FETCH; called at posedge+1 in FETCH.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int wait_ph, input int waits,
                             input int e_cyc, input int e_rw, input int e_rwat, input int e_mw,
                             input int e_ill, input int e_pc, input int e_alu3, input int e_ps3);
        int k = 0, rw_n = 0, rw_at = 0, mw_n = 0, ill_n = 0, pc_n = 0;
        int alu3 = -1, ps3 = -1, wl = waits;
        bit left = 1'b0;
        op = o; funct = f; zero = z;
        do begin
            if (ph == wait_ph && wl > 0) begin
                mem_ready = 1'b0;
                wl--;
            end else if (ph == M_FETCH || ph == M_MEMRD || ph == M_MEMWR) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = (k % 2 == 1);
            end
            @(negedge clk);
            k++;
            if (regwrite)   begin rw_n++; rw_at = k; end
            if (memwrite)   mw_n++;
            if (illegal_op) ill_n++;
            if (pcen)       pc_n++;
            if (k == 3)     begin alu3 = int'(alucontrol); ps3 = int'(pcsrc); end
            @(posedge clk);
            #1;
            if (ph != M_FETCH) left = 1'b1;
        end while ((!left || ph != M_FETCH) && k < 40);
        check({name, " cycles"}, k, e_cyc);
        check({name, " regwrite_cycles"}, rw_n, e_rw);
        check({name, " regwrite_at"}, rw_at, e_rwat);
        check({name, " memwrite_cycles"}, mw_n, e_mw);
        check({name, " illegal_cycles"}, ill_n, e_ill);
        check({name, " pcen_cycles"}, pc_n, e_pc);
        if (e_alu3 >= 0) check({name, " alucontrol_c3"}, alu3, e_alu3);
        if (e_ps3 >= 0)  check({name, " pcsrc_c3"}, ps3, e_ps3);
    endtask

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #1 check("reset_vector", int'(got), int'(RST_VEC));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        //        name      op         funct      z     wait_ph  w  cyc rw at mw il pc alu ps
        run_instr("lw",     6'b100011, 6'b000000, 1'b0, M_FETCH, 0, 5, 1, 5, 0, 0, 1, 2, 0);
        run_instr("sw",     6'b101011, 6'b000000, 1'b0, M_FETCH, 0, 4, 0, 0, 1, 0, 1, 2, 0);
        run_instr("slt",    6'b000000, 6'b101010, 1'b0, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 7, 0);
        run_instr("add",    6'b000000, 6'b100000, 1'b1, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 2, 0);
        run_instr("sub",    6'b000000, 6'b100010, 1'b0, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 6, 0);
        run_instr("and",    6'b000000, 6'b100100, 1'b0, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 0, 0);
        run_instr("or",     6'b000000, 6'b100101, 1'b0, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 1, 0);
        run_instr("badfn",  6'b000000, 6'b000111, 1'b0, M_FETCH, 0, 3, 0, 0, 0, 1, 1, -1, 0);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, M_FETCH, 0, 3, 0, 0, 0, 0, 2, 6, 1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, M_FETCH, 0, 3, 0, 0, 0, 0, 1, 6, 1);
        run_instr("addi",   6'b001000, 6'b000000, 1'b0, M_FETCH, 0, 4, 1, 4, 0, 0, 1, 2, 0);
        run_instr("j",      6'b000010, 6'b000000, 1'b0, M_FETCH, 0, 3, 0, 0, 0, 0, 2, 0, 2);
        run_instr("illop",  6'b111111, 6'b000000, 1'b0, M_FETCH, 0, 2, 0, 0, 0, 1, 1, -1, -1);
        run_instr("sw_w3",  6'b101011, 6'b000000, 1'b0, M_MEMWR, 3, 7, 0, 0, 4, 0, 1, 2, 0);
        run_instr("lw_w2",  6'b100011, 6'b000000, 1'b0, M_MEMRD, 2, 7, 1, 7, 0, 0, 1, 2, 0);
        run_instr("addi_f2",6'b001000, 6'b000000, 1'b0, M_FETCH, 2, 6, 1, 6, 0, 0, 1, 2, 0);

        // Abort a store in MEMWR with reset.
        op = 6'b101011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 10 && ph != M_MEMWR; i++) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("memwrite_before_reset", int'(memwrite), 1);
        #2 reset = 1'b0;
        #1;
        check("memwrite_on_reset", int'(memwrite), 0);
        check("vector_on_reset", int'(got), int'(RST_VEC));
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_mem_req", int'(mem_req), 1);
        check("post_reset_iord", int'(iord), 0);
        @(posedge clk);
        #1;
        run_instr("lw_post", 6'b100011, 6'b000000, 1'b0, M_FETCH, 0, 5, 1, 5, 0, 0, 1, 2, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu4_mc_ctrl.md
CPU4_MC_CTRL -- requirements
Module: cpu4_mc_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants.
REQ-002 The block SHALL have port clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-low reset; the block has one clock.
REQ-004 The block SHALL have port op  in  6  instruction opcode field, valid while the instruction register holds the current instruction.
REQ-005 The block SHALL have port funct  in  6  R-type function field.
REQ-006 The block SHALL have port zero  in  1  ALU zero flag.
REQ-007 The block SHALL have port mem_ready  in  1  memory completes the requested access this cycle.
REQ-008 The block SHALL have port mem_req  out  1  memory access request, held until mem_ready.
REQ-009 The block SHALL have ports iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-010 The block SHALL have ports alusrcb  out  2, pcsrc  out  2, alucontrol  out  3, pcen  out  1  datapath controls.
REQ-011 The block SHALL have port illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-012 Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-013 alucontrol encodings: ADD 010, SUB 110, AND 000, OR 001, SLT 111; funct 100000/100010/100100/100101/101010 SHALL map to ADD/SUB/AND/OR/SLT in EXECUTE.
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-015 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=00; irwrite and pcen SHALL be 1 only in the cycle mem_ready=1, which also moves the FSM to DECODE; otherwise the FSM stays in FETCH.
REQ-016 DECODE: alusrca=0, alusrcb=11, alucontrol=ADD; next state LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEXEC, J->JUMP, any other op->FETCH with illegal_op=1.
REQ-017 MEMADR: alusrca=1, alusrcb=10, alucontrol=ADD; next MEMRD for LW, MEMWR for SW.
REQ-018 MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB.
REQ-019 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-020 MEMWR: mem_req=1, iord=1, memwrite=1; memwrite and mem_req SHALL stay high until mem_ready, then FETCH.
REQ-021 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct; next ALUWB; unsupported funct SHALL pulse illegal_op and go to FETCH with no register write.
REQ-022 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, alucontrol=SUB, pcsrc=01, pcen=zero; next FETCH.
REQ-024 ADDIEXEC: alusrca=1, alusrcb=10, alucontrol=ADD; next ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-026 Any output not listed for a state SHALL be 0; all outputs SHALL be Moore decodes of state, except irwrite/pcen in FETCH (gated by mem_ready) and pcen in BRANCH (gated by zero).
REQ-027 CPI without wait states: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3; each mem_ready=0 cycle SHALL add exactly one cycle.
REQ-028 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force state FETCH asynchronously; all outputs SHALL then be 0 except mem_req=1, alusrcb=01, alucontrol=010.
REQ-030 Reset asserted mid-access SHALL abort it; memwrite SHALL drop in the same cycle reset asserts; the first access after release SHALL be an instruction fetch.

Structure
REQ-031 Opcode, funct, alucontrol and state encodings SHALL reside in the shared defines file.
REQ-032 The funct-to-alucontrol decode SHALL be a combinational sub-module cpu4_aludec; the FSM register SHALL use the codebase's reset flop primitive.

Verification
REQ-033 Reset released, mem_ready=1 always, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-034 op=000000, funct=101010 -> alucontrol=111 in EXECUTE, regdst=1 and regwrite=1 in the next cycle, back to FETCH on cycle 5.
REQ-035 op=000100 with zero=1 then zero=0 -> pcen=1 with pcsrc=01 in the first BRANCH, pcen=0 in the second.
REQ-036 op=101011, mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, regwrite never 1, instruction takes 7 cycles.
REQ-037 op=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no regwrite/memwrite.
REQ-038 reset asserted during MEMWR with mem_ready=0 -> memwrite=0 immediately; after release, first cycle in FETCH with mem_req=1, iord=0.
